// File: rtl/nios_memarb_pkg.sv
// rtl/nios_memarb_pkg.sv - shared types and defaults for the on-chip RAM arbiter
package nios_memarb_pkg;

  localparam int          MEMARB_ADDR_W = 13;
  localparam int          MEMARB_DATA_W = 32;
  localparam int unsigned MEMARB_DEPTH  = 6500;

  typedef enum logic {OWN_M0, OWN_M1} owner_t;
  typedef enum logic {ST_SCRUB, ST_RUN} state_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
    logic   oor;
  } rd_track_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant, one-hot output
module rr_arb2
  import nios_memarb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     rr_last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (rr_last == OWN_M1) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/nios_onchip_mem_arbiter.sv
// rtl/nios_onchip_mem_arbiter.sv - two-master Avalon-MM arbiter for the on-chip RAM
// Optional power-up zero scrub enabled by NIOS_MEMARB_SCRUB_EN.
module nios_onchip_mem_arbiter
  import nios_memarb_pkg::*;
#(
  parameter int          ADDR_W = MEMARB_ADDR_W,
  parameter int          DATA_W = MEMARB_DATA_W,
  parameter int unsigned DEPTH  = MEMARB_DEPTH,
  parameter int          RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef NIOS_MEMARB_SCRUB_EN
  output logic                  scrub_busy,
`endif
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic                  oor_error
);

  localparam int BE_W = DATA_W / 8;

  logic              run;
  logic [1:0]        req, gnt;
  owner_t            rr_last, win_owner;
  logic              acc, win_read, win_write, win_oor;
  logic [ADDR_W-1:0] win_addr;
  logic [BE_W-1:0]   win_be;
  logic [DATA_W-1:0] win_wd, ret_data, hold0, hold1;
  rd_track_t         pipe [RD_LAT];
  rd_track_t         tail;
  logic              rv0, rv1;

`ifdef NIOS_MEMARB_SCRUB_EN
  state_t            state;
  logic [ADDR_W-1:0] scrub_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_SCRUB;
      scrub_addr <= '0;
      scrub_busy <= 1'b1;
    end else if (state == ST_SCRUB) begin
      if (scrub_addr == ADDR_W'(DEPTH - 1)) begin
        state      <= ST_RUN;
        scrub_busy <= 1'b0;
      end else begin
        scrub_addr <= scrub_addr + ADDR_W'(1);
      end
    end
  end

  assign run = (state == ST_RUN);
`else
  assign run = 1'b1;
`endif

  // A write asserted together with a read is the command; the read is dropped.
  assign req = {m1_read | m1_write, m0_read | m0_write} & {2{run & ~reset}};

  rr_arb2 u_rr_arb2 (
    .req     (req),
    .rr_last (rr_last),
    .gnt     (gnt)
  );

  assign acc = |gnt;

  always_comb begin
    if (gnt[1]) begin
      win_owner = OWN_M1;
      win_read  = m1_read & ~m1_write;
      win_write = m1_write;
      win_addr  = m1_address;
      win_be    = m1_byteenable;
      win_wd    = m1_writedata;
    end else begin
      win_owner = OWN_M0;
      win_read  = m0_read & ~m0_write;
      win_write = m0_write;
      win_addr  = m0_address;
      win_be    = m0_byteenable;
      win_wd    = m0_writedata;
    end
  end

  assign win_oor        = 32'(win_addr) >= DEPTH;
  assign m0_waitrequest = ~gnt[0];
  assign m1_waitrequest = ~gnt[1];
  assign mem_clken      = 1'b1;

  always_comb begin
    mem_chipselect = acc & ~win_oor;
    mem_write      = acc & win_write & ~win_oor;
    mem_address    = win_addr;
    mem_byteenable = win_be;
    mem_writedata  = win_wd;
`ifdef NIOS_MEMARB_SCRUB_EN
    if (!reset && state == ST_SCRUB) begin
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
      mem_address    = scrub_addr;
      mem_byteenable = '1;
      mem_writedata  = '0;
    end
`endif
  end

  // One tracker slot per cycle so the tail lines up with the RAM q output.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '{valid: 1'b0, owner: OWN_M0, oor: 1'b0};
    end else begin
      pipe[0] <= '{valid: acc & win_read, owner: win_owner, oor: win_oor};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tail     = pipe[RD_LAT-1];
  assign ret_data = tail.oor ? '0 : mem_readdata;
  assign rv0      = ~reset & tail.valid & (tail.owner == OWN_M0);
  assign rv1      = ~reset & tail.valid & (tail.owner == OWN_M1);

  assign m0_readdatavalid = rv0;
  assign m1_readdatavalid = rv1;
  assign m0_readdata      = rv0 ? ret_data : hold0;
  assign m1_readdata      = rv1 ? ret_data : hold1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last   <= OWN_M1;
      oor_error <= 1'b0;
      hold0     <= '0;
      hold1     <= '0;
    end else begin
      if (acc) rr_last <= win_owner;
      if (acc && win_oor) oor_error <= 1'b1;
      if (rv0) hold0 <= ret_data;
      if (rv1) hold1 <= ret_data;
    end
  end

endmodule

// File: tb/tb_nios_onchip_mem_arbiter.sv
// tb/tb_nios_onchip_mem_arbiter.sv - directed bench for nios_onchip_mem_arbiter
module tb_nios_onchip_mem_arbiter;

`ifdef NIOS_MEMARB_SCRUB_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [12:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic        mem_chipselect, mem_write, mem_clken, oor_error;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata, mem_readdata;
`ifdef NIOS_MEMARB_SCRUB_EN
  logic        scrub_busy;
`endif

  int passed = 0;
  int total  = 0;

  nios_onchip_mem_arbiter #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
`ifdef NIOS_MEMARB_SCRUB_EN
    .scrub_busy(scrub_busy),
`endif
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_address(mem_address),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .oor_error(oor_error)
  );

  always #5 clk = ~clk;

  // RAM model: q registered once (RD_LAT=1) or twice (RD_LAT=2); preloaded with A5A5_<addr>.
  logic [31:0] ram [8192];
  logic [31:0] q1, q2;
  bit          ram_init;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 8192; i++) ram[i] <= 32'hA5A5_0000 | 32'(i);
      ram_init <= 1'b1;
    end else if (mem_clken) begin
      q1 <= ram[mem_address];
      q2 <= q1;
      if (mem_chipselect && mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
    end
  end

  assign mem_readdata = (RD_LAT == 2) ? q2 : q1;

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  task automatic cmd(input int m, input logic rd, input logic wr, input logic [12:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    end
  endtask

  task automatic seed(input int m, input logic [12:0] a, input logic [31:0] d);
    @(negedge clk); idle(); cmd(m, 0, 1, a, d, 4'hF);
    @(posedge clk); #1 idle();
  endtask

  task automatic release_reset();
    idle(); reset = 0;
`ifdef NIOS_MEMARB_SCRUB_EN
    begin
      int n;
      n = 0;
      while (scrub_busy === 1'b1 && n < 7000) begin @(negedge clk); n++; end
    end
`endif
  endtask

  task automatic do_reset();
    @(negedge clk); idle(); reset = 1;
    repeat (2) @(negedge clk);
    release_reset();
  endtask

  task automatic test_reset();
    reset = 1; idle();
    m0_address = 0; m1_address = 0; m0_writedata = 0; m1_writedata = 0;
    m0_byteenable = 0; m1_byteenable = 0;
    repeat (3) @(negedge clk);
    m0_read = 1; m1_write = 1; #1;
    total++; if (m0_waitrequest !== 1'b1) $display("FAIL rst_m0_wait act=%b exp=1", m0_waitrequest); else passed++;
    total++; if (m1_waitrequest !== 1'b1) $display("FAIL rst_m1_wait act=%b exp=1", m1_waitrequest); else passed++;
    total++; if (m0_readdatavalid !== 1'b0) $display("FAIL rst_m0_rdv act=%b exp=0", m0_readdatavalid); else passed++;
    total++; if (m1_readdatavalid !== 1'b0) $display("FAIL rst_m1_rdv act=%b exp=0", m1_readdatavalid); else passed++;
    total++; if (m0_readdata !== 32'h0) $display("FAIL rst_m0_rd act=%h exp=0", m0_readdata); else passed++;
    total++; if (m1_readdata !== 32'h0) $display("FAIL rst_m1_rd act=%h exp=0", m1_readdata); else passed++;
    total++; if (mem_chipselect !== 1'b0) $display("FAIL rst_cs act=%b exp=0", mem_chipselect); else passed++;
    total++; if (mem_write !== 1'b0) $display("FAIL rst_we act=%b exp=0", mem_write); else passed++;
    total++; if (mem_clken !== 1'b1) $display("FAIL rst_clken act=%b exp=1", mem_clken); else passed++;
    total++; if (oor_error !== 1'b0) $display("FAIL rst_oor act=%b exp=0", oor_error); else passed++;
    release_reset();
  endtask

  task automatic test_write_read();
    @(negedge clk); idle(); cmd(0, 0, 1, 13'h010, 32'hDEADBEEF, 4'hF); #1;
    total++; if (m0_waitrequest !== 1'b0) $display("FAIL wr_m0_wait act=%b exp=0", m0_waitrequest); else passed++;
    total++; if (m1_waitrequest !== 1'b1) $display("FAIL wr_m1_wait act=%b exp=1", m1_waitrequest); else passed++;
    total++; if (mem_chipselect !== 1'b1 || mem_write !== 1'b1) $display("FAIL wr_cs_we act=%b%b exp=11", mem_chipselect, mem_write); else passed++;
    total++; if (mem_address !== 13'h010) $display("FAIL wr_addr act=%h exp=010", mem_address); else passed++;
    total++; if (mem_writedata !== 32'hDEADBEEF) $display("FAIL wr_data act=%h exp=deadbeef", mem_writedata); else passed++;
    @(negedge clk); idle(); cmd(0, 1, 0, 13'h010, 32'h0, 4'hF); #1;
    total++; if (m0_waitrequest !== 1'b0) $display("FAIL rd_m0_wait act=%b exp=0", m0_waitrequest); else passed++;
    total++; if (mem_chipselect !== 1'b1 || mem_write !== 1'b0) $display("FAIL rd_cs_we act=%b%b exp=10", mem_chipselect, mem_write); else passed++;
    for (int k = 0; k < RD_LAT; k++) begin @(negedge clk); idle(); #1; end
    total++; if (m0_readdatavalid !== 1'b1) $display("FAIL rd_m0_rdv act=%b exp=1", m0_readdatavalid); else passed++;
    total++; if (m0_readdata !== 32'hDEADBEEF) $display("FAIL rd_m0_data act=%h exp=deadbeef", m0_readdata); else passed++;
    total++; if (m1_readdatavalid !== 1'b0) $display("FAIL rd_m1_rdv act=%b exp=0", m1_readdatavalid); else passed++;
    @(negedge clk); #1;
    total++; if (m0_readdatavalid !== 1'b0) $display("FAIL rd_pulse act=%b exp=0", m0_readdatavalid); else passed++;
    total++; if (m0_readdata !== 32'hDEADBEEF) $display("FAIL rd_hold act=%h exp=deadbeef", m0_readdata); else passed++;
  endtask

  task automatic test_alternate();
    logic odd;
    do_reset();
    // Seeding m0 then m1 leaves rr_last = m1, so m0 still wins the first tie.
    seed(0, 13'h020, 32'h1111AAAA);
    seed(1, 13'h030, 32'h2222BBBB);
    for (int i = 0; i < 6 + RD_LAT; i++) begin
      @(negedge clk);
      if (i < 6) begin
        cmd(0, 1, 0, 13'h020, 32'h0, 4'hF);
        cmd(1, 1, 0, 13'h030, 32'h0, 4'hF);
      end else idle();
      #1;
      if (i < 6) begin
        odd = (i % 2) != 0;
        total++; if (m0_waitrequest !== odd) $display("FAIL alt_m0_wait[%0d] act=%b exp=%b", i, m0_waitrequest, odd); else passed++;
        total++; if (m1_waitrequest !== !odd) $display("FAIL alt_m1_wait[%0d] act=%b exp=%b", i, m1_waitrequest, !odd); else passed++;
      end
      if (i >= RD_LAT) begin
        odd = ((i - RD_LAT) % 2) != 0;
        total++; if (m0_readdatavalid !== !odd) $display("FAIL alt_m0_rdv[%0d] act=%b exp=%b", i, m0_readdatavalid, !odd); else passed++;
        total++; if (m1_readdatavalid !== odd) $display("FAIL alt_m1_rdv[%0d] act=%b exp=%b", i, m1_readdatavalid, odd); else passed++;
        if (!odd) begin
          total++; if (m0_readdata !== 32'h1111AAAA) $display("FAIL alt_m0_data[%0d] act=%h exp=1111aaaa", i, m0_readdata); else passed++;
        end else begin
          total++; if (m1_readdata !== 32'h2222BBBB) $display("FAIL alt_m1_data[%0d] act=%h exp=2222bbbb", i, m1_readdata); else passed++;
        end
      end
    end
    @(negedge clk); #1;
    total++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) $display("FAIL alt_drain act=%b%b exp=00", m0_readdatavalid, m1_readdatavalid); else passed++;
  endtask

  task automatic test_byte_enable();
    seed(1, 13'h040, 32'hAABBCCDD);
    @(negedge clk); idle(); cmd(1, 0, 1, 13'h040, 32'h11223344, 4'h4); #1;
    total++; if (m1_waitrequest !== 1'b0) $display("FAIL be_m1_wait act=%b exp=0", m1_waitrequest); else passed++;
    total++; if (mem_byteenable !== 4'h4) $display("FAIL be_lanes act=%h exp=4", mem_byteenable); else passed++;
    @(negedge clk); idle(); cmd(1, 1, 0, 13'h040, 32'h0, 4'hF); #1;
    for (int k = 0; k < RD_LAT; k++) begin @(negedge clk); idle(); #1; end
    total++; if (m1_readdatavalid !== 1'b1) $display("FAIL be_m1_rdv act=%b exp=1", m1_readdatavalid); else passed++;
    total++; if (m1_readdata !== 32'hAA22CCDD) $display("FAIL be_m1_data act=%h exp=aa22ccdd", m1_readdata); else passed++;
    total++; if (m0_readdatavalid !== 1'b0) $display("FAIL be_m0_rdv act=%b exp=0", m0_readdatavalid); else passed++;
    total++; if (m0_readdata !== 32'h1111AAAA) $display("FAIL be_m0_hold act=%h exp=1111aaaa", m0_readdata); else passed++;
  endtask

  task automatic test_rw_collision();
    @(negedge clk); idle(); cmd(0, 1, 1, 13'h050, 32'h0BADCAFE, 4'hF); #1;
    total++; if (mem_write !== 1'b1) $display("FAIL rw_write_wins act=%b exp=1", mem_write); else passed++;
    for (int k = 0; k < RD_LAT; k++) begin @(negedge clk); idle(); #1; end
    total++; if (m0_readdatavalid !== 1'b0) $display("FAIL rw_read_dropped act=%b exp=0", m0_readdatavalid); else passed++;
  endtask

  task automatic test_oor();
    @(negedge clk); idle(); cmd(0, 1, 0, 13'h1964, 32'h0, 4'hF); #1;
    total++; if (m0_waitrequest !== 1'b0) $display("FAIL oor_m0_wait act=%b exp=0", m0_waitrequest); else passed++;
    total++; if (mem_chipselect !== 1'b0) $display("FAIL oor_cs act=%b exp=0", mem_chipselect); else passed++;
    for (int k = 0; k < RD_LAT; k++) begin @(negedge clk); idle(); #1; end
    total++; if (m0_readdatavalid !== 1'b1) $display("FAIL oor_rdv act=%b exp=1", m0_readdatavalid); else passed++;
    total++; if (m0_readdata !== 32'h0) $display("FAIL oor_data act=%h exp=0", m0_readdata); else passed++;
    total++; if (oor_error !== 1'b1) $display("FAIL oor_flag act=%b exp=1", oor_error); else passed++;
    @(negedge clk); idle(); cmd(1, 0, 1, 13'h1FFF, 32'hCAFEF00D, 4'hF); #1;
    total++; if (m1_waitrequest !== 1'b0) $display("FAIL oor_m1_wait act=%b exp=0", m1_waitrequest); else passed++;
    total++; if (mem_write !== 1'b0 || mem_chipselect !== 1'b0) $display("FAIL oor_we act=%b%b exp=00", mem_chipselect, mem_write); else passed++;
    @(negedge clk); idle(); #1;
    total++; if (ram[13'h1FFF] !== 32'hA5A51FFF) $display("FAIL oor_ram act=%h exp=a5a51fff", ram[13'h1FFF]); else passed++;
    total++; if (oor_error !== 1'b1) $display("FAIL oor_sticky act=%b exp=1", oor_error); else passed++;
  endtask

  task automatic test_boundary();
    @(negedge clk); idle(); cmd(0, 0, 1, 13'h1963, 32'h600DF00D, 4'hF); #1;
    total++; if (mem_chipselect !== 1'b1 || mem_write !== 1'b1) $display("FAIL last_cs_we act=%b%b exp=11", mem_chipselect, mem_write); else passed++;
    @(negedge clk); idle(); cmd(1, 1, 0, 13'h1963, 32'h0, 4'hF); #1;
    for (int k = 0; k < RD_LAT; k++) begin @(negedge clk); idle(); #1; end
    total++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h600DF00D) $display("FAIL last_rd act=%b/%h exp=1/600df00d", m1_readdatavalid, m1_readdata); else passed++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk); idle(); cmd(1, 1, 0, 13'h040, 32'h0, 4'hF); #1;
    total++; if (m1_waitrequest !== 1'b0) $display("FAIL rm_accept act=%b exp=0", m1_waitrequest); else passed++;
    @(posedge clk); #1 reset = 1;
    @(negedge clk); #1;
    total++; if (m1_readdatavalid !== 1'b0) $display("FAIL rm_rdv_discard act=%b exp=0", m1_readdatavalid); else passed++;
    total++; if (m1_waitrequest !== 1'b1) $display("FAIL rm_wait act=%b exp=1", m1_waitrequest); else passed++;
    total++; if (mem_chipselect !== 1'b0) $display("FAIL rm_cs act=%b exp=0", mem_chipselect); else passed++;
    @(negedge clk); #1;
    total++; if (m1_readdatavalid !== 1'b0 || m0_readdatavalid !== 1'b0) $display("FAIL rm_rdv_next act=%b%b exp=00", m0_readdatavalid, m1_readdatavalid); else passed++;
    total++; if (m1_readdata !== 32'h0 || m0_readdata !== 32'h0) $display("FAIL rm_rd_clear act=%h/%h exp=0/0", m0_readdata, m1_readdata); else passed++;
    total++; if (oor_error !== 1'b0) $display("FAIL rm_oor_clear act=%b exp=0", oor_error); else passed++;
    total++; if (mem_write !== 1'b0 || mem_clken !== 1'b1) $display("FAIL rm_mem act=%b%b exp=01", mem_write, mem_clken); else passed++;
    release_reset();
    @(negedge clk); #1;
    total++; if (m1_readdatavalid !== 1'b0) $display("FAIL rm_no_late_rdv act=%b exp=0", m1_readdatavalid); else passed++;
  endtask

`ifdef NIOS_MEMARB_SCRUB_EN
  task automatic test_scrub();
    int cnt;
    @(negedge clk); idle(); reset = 1;
    @(negedge clk); cmd(0, 1, 0, 13'h000, 32'h0, 4'hF); reset = 0;
    cnt = 0;
    while (scrub_busy === 1'b1 && cnt < 7000) begin
      #1;
      if (cnt == 100) begin
        total++; if (m0_waitrequest !== 1'b1) $display("FAIL scrub_wait act=%b exp=1", m0_waitrequest); else passed++;
        total++; if (mem_address !== 13'd100 || mem_write !== 1'b1 || mem_writedata !== 32'h0)
          $display("FAIL scrub_drive act=%h/%b/%h exp=064/1/0", mem_address, mem_write, mem_writedata); else passed++;
      end
      cnt++;
      @(negedge clk);
    end
    total++; if (cnt !== 6500) $display("FAIL scrub_len act=%0d exp=6500", cnt); else passed++;
    #1;
    total++; if (m0_waitrequest !== 1'b0) $display("FAIL scrub_first_acc act=%b exp=0", m0_waitrequest); else passed++;
    for (int k = 0; k < RD_LAT; k++) begin @(negedge clk); idle(); #1; end
    total++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h0) $display("FAIL scrub_rd0 act=%b/%h exp=1/0", m0_readdatavalid, m0_readdata); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_byte_enable();
    test_rw_collision();
    test_oor();
    test_boundary();
    test_reset_mid();
`ifdef NIOS_MEMARB_SCRUB_EN
    test_scrub();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout act=%0d/%0d exp=finished", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nios_onchip_mem_arbiter.md
Name: nios_onchip_mem_arbiter

Overview:
- Two-requester Avalon-MM arbiter in front of the single-port on-chip RAM (32-bit data, 13-bit word address, 6500 words, byte enables).
- Lets two masters share the RAM: a CPU data master (m0) and a DMA/peripheral master (m1).
- Round-robin grant; at most one command per cycle to the RAM.
- Tracks read latency and routes readdata back to the issuing master, with out-of-range address protection.

Parameters:
- ADDR_W, 13, word address width, shared by both masters and the RAM.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- DEPTH, 6500, valid words; addresses >= DEPTH are out of range.
- RD_LAT, 1, RAM read latency in cycles; legal values are 1 (unregistered q) and 2 (registered q).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_read / m0_write  in  1 / 1  m0 command strobes
- m0_address  in  ADDR_W  m0 word address
- m0_byteenable  in  DATA_W/8  m0 byte lanes
- m0_writedata  in  DATA_W  m0 write data
- m0_waitrequest  out  1  m0 stall
- m0_readdata  out  DATA_W  m0 read data
- m0_readdatavalid  out  1  m0 read return strobe
- m1_*  (same nine signals as m0_*)  m1 port
- mem_chipselect / mem_write  out  1 / 1  RAM select and write enable
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  DATA_W/8  RAM byte lanes
- mem_writedata  out  DATA_W  RAM write data
- mem_clken  out  1  RAM clock enable
- mem_readdata  in  DATA_W  RAM q output
- oor_error  out  1  sticky out-of-range access flag

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - all waitrequests = 1, all readdatavalids = 0, readdata = 0
  - mem_chipselect = 0, mem_write = 0, mem_clken = 1
  - oor_error = 0, rr_last = m1 (so m0 wins the first tie)
- Request: mX_req = mX_read | mX_write.
  - If read and write are both asserted, the write wins and the read is dropped.
- Grant (combinational, same cycle):
  - only one requesting master: it wins
  - both requesting: the master not equal to rr_last wins
  - on every accepted command, rr_last <= winner
- Waitrequest:
  - the winner sees waitrequest = 0 in the cycle its command drives the mem_* ports; this is the accept cycle
  - the loser and idle masters see waitrequest = 1
  - masters hold their command until accepted
- Memory drive:
  - mem_* mirror the winner's command
  - mem_chipselect = 1 only for an in-range accepted command
  - mem_write = accepted write & in-range
  - no winner: mem_chipselect = 0 and mem_write = 0
- Read tracking:
  - RD_LAT-deep shift register of {valid, owner, oor}, one entry pushed per cycle.
  - A read accepted at cycle N returns at cycle N+RD_LAT: owner's readdatavalid = 1 for one cycle, readdata = mem_readdata (or 0 if oor).
  - Non-owner readdata holds its last value.
  - Back-to-back reads from alternating masters return in issue order, one per cycle, with no bubbles.
- Out of range (address >= DEPTH):
  - the command is still accepted, so waitrequest drops
  - writes are suppressed
  - reads return 0 with readdatavalid
  - oor_error sets and clears only on reset
- Reset mid-operation: pending read returns are discarded; no readdatavalid is issued for them.
- No state machine beyond rr_last, the tracker and the optional scrub FSM.

Optional Feature:
- Macro: NIOS_MEMARB_SCRUB_EN.
- With the macro defined:
  - After reset, FSM SCRUB writes 0 with all byte lanes to addresses 0..DEPTH-1, one word per cycle.
  - Both masters see waitrequest = 1 during the scrub.
  - When address DEPTH-1 is written, the FSM moves to RUN; arbitration starts the next cycle.
  - Scrub takes DEPTH cycles.
  - A reset during the scrub restarts it at address 0.
  - Output scrub_busy (1 bit) = 1 in SCRUB.
- Without the macro: the block enters RUN directly out of reset and the scrub_busy port is absent.

Decomposition:
- Package nios_memarb_pkg:
  - ADDR_W/DATA_W/DEPTH defaults
  - owner_t enum {OWN_M0, OWN_M1}
  - state_t {ST_SCRUB, ST_RUN}
  - rd_track_t struct {valid, owner, oor}
- Sub-module rr_arb2: two-way round-robin grant from req[1:0] and rr_last, producing a one-hot gnt. Purely combinational, instanced once.

Test Plan:
- m0 write addr 0x010, data 0xDEADBEEF, be 0xF; then m0 read 0x010 -> waitrequest 0 on the issue cycle; m0_readdatavalid exactly 1 cycle after the read accept with 0xDEADBEEF; m1 sees no readdatavalid.
- m0 and m1 both read continuously for 6 cycles -> grants alternate m0,m1,m0,... starting with m0 after reset; returns alternate the same way with no gaps.
- m1 write 0x11223344 be 0x4 to a word holding 0xAABBCCDD, then read -> 0xAA22CCDD.
- m0 read 0x1964 (6500) -> readdatavalid with 0, oor_error = 1, mem_chipselect = 0; m1 write to 0x1FFF -> RAM unchanged.
- Reset asserted the cycle after m1 read accept -> no m1_readdatavalid; all outputs at reset values the next cycle.
- With NIOS_MEMARB_SCRUB_EN, RD_LAT=2 -> scrub_busy high for 6500 cycles, waitrequest held; then a read of 0x000 returns 0 two cycles after accept.
